// File: rtl/cache_dma_engine_if.sv
// Word-wide main-memory port used by the cache DMA engine.
// The master side issues single-word transactions and the slave side answers
// with a grant, plus read data flagged by rvalid.
interface cache_dma_engine_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [WORD_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [WORD_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/cache_dma_engine.sv
// Memory-side responder for the unified cache. A 512-bit line fill or eviction
// becomes 16 sequential 32-bit transactions on the memory port; completion is
// reported back to the cache with single-cycle pulses. Evictions win over fills
// so a dirty victim always reaches memory before the same line is refilled.
module cache_dma_engine #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 512,
  parameter int OFFS_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] addr_out_request_DMA_i,
  input  logic              request_DMA_i,
  input  logic [LINE_W-1:0] data_out_evict_DMA_i,
  input  logic [ADDR_W-1:0] addr_out_evict_DMA_i,
  input  logic              evict_DMA_i,
  output logic [LINE_W-1:0] data_in_request_DMA_o,
  output logic [ADDR_W-1:0] addr_in_request_DMA_o,
  output logic              request_valid_DMA_o,
  output logic              evict_DMA_o,
  cache_dma_engine_if.master mem
);

  localparam int WORDS  = LINE_W / WORD_W;
  localparam int CNT_W  = $clog2(WORDS);
  localparam int BYTE_W = OFFS_W - CNT_W;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_EVICT      = 3'd1,
    S_EVICT_DONE = 3'd2,
    S_FILL_REQ   = 3'd3,
    S_FILL_WAIT  = 3'd4,
    S_FILL_DONE  = 3'd5,
    S_COOL       = 3'd6
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic [LINE_W-1:0] evict_line_q;   // shifts down one word per granted write
  logic [LINE_W-1:0] fill_line_q;    // doubles as the fill data output
  logic [ADDR_W-1:0] fill_addr_q;
  logic              fill_done_q;
  logic              evict_done_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_wdata_q;

  logic [ADDR_W-1:0] evict_base_s;
  logic [ADDR_W-1:0] fill_base_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [ADDR_W-1:0] next_word_addr_s;
  logic              unused_s;

  // Line-align incoming addresses; the next word address stays inside the line
  // because only the counter bits change.
  assign evict_base_s     = {addr_out_evict_DMA_i[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
  assign fill_base_s      = {addr_out_request_DMA_i[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
  assign cnt_inc_s        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign next_word_addr_s = {base_q[ADDR_W-1:OFFS_W], cnt_inc_s, {BYTE_W{1'b0}}};
  assign unused_s         = ^{addr_out_request_DMA_i[OFFS_W-1:0], addr_out_evict_DMA_i[OFFS_W-1:0]};

  // Transfer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      evict_line_q <= '0;
      fill_line_q  <= '0;
      fill_addr_q  <= '0;
      fill_done_q  <= 1'b0;
      evict_done_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      fill_done_q  <= 1'b0;
      evict_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (evict_DMA_i) begin
            base_q       <= evict_base_s;
            evict_line_q <= data_out_evict_DMA_i;
            cnt_q        <= '0;
            mem_req_q    <= 1'b1;
            mem_we_q     <= 1'b1;
            mem_addr_q   <= evict_base_s;
            mem_wdata_q  <= data_out_evict_DMA_i[WORD_W-1:0];
            state_q      <= S_EVICT;
          end else if (request_DMA_i) begin
            base_q      <= fill_base_s;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= fill_base_s;
            mem_wdata_q <= '0;
            state_q     <= S_FILL_REQ;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_EVICT: begin
          if (mem.mem_gnt_i) begin
            if (cnt_q == LAST_WORD) begin
              mem_req_q    <= 1'b0;
              mem_we_q     <= 1'b0;
              evict_done_q <= 1'b1;
              state_q      <= S_EVICT_DONE;
            end else begin
              cnt_q        <= cnt_inc_s;
              evict_line_q <= evict_line_q >> WORD_W;
              mem_addr_q   <= next_word_addr_s;
              mem_wdata_q  <= evict_line_q[2*WORD_W-1:WORD_W];
            end
          end
        end
        S_EVICT_DONE: begin
          state_q <= S_COOL;
        end
        S_FILL_REQ: begin
          if (mem.mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= S_FILL_WAIT;
          end
        end
        S_FILL_WAIT: begin
          if (mem.mem_rvalid_i) begin
            fill_line_q[WORD_W*cnt_q +: WORD_W] <= mem.mem_rdata_i;
            if (cnt_q == LAST_WORD) begin
              fill_addr_q <= base_q;
              fill_done_q <= 1'b1;
              state_q     <= S_FILL_DONE;
            end else begin
              cnt_q      <= cnt_inc_s;
              mem_req_q  <= 1'b1;
              mem_addr_q <= next_word_addr_s;
              state_q    <= S_FILL_REQ;
            end
          end
        end
        S_FILL_DONE: begin
          state_q <= S_COOL;
        end
        S_COOL: begin
          // Requests still held after the pulse are deliberately not sampled here.
          state_q <= S_IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign data_in_request_DMA_o = fill_line_q;
  assign addr_in_request_DMA_o = fill_addr_q;
  assign request_valid_DMA_o   = fill_done_q;
  assign evict_DMA_o           = evict_done_q;
  assign mem.mem_req_o         = mem_req_q;
  assign mem.mem_we_o          = mem_we_q;
  assign mem.mem_addr_o        = mem_addr_q;
  assign mem.mem_wdata_o       = mem_wdata_q;

endmodule

// File: tb/tb_cache_dma_engine.sv
// Scoreboard bench for cache_dma_engine: stimulus pushes expected memory
// transactions and completions; the memory model and the completion monitor pop
// and compare them as the DUT produces them.
module tb_cache_dma_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  addr_req;
  logic         req;
  logic [511:0] ev_data;
  logic [31:0]  addr_ev;
  logic         ev;
  logic [511:0] fill_data;
  logic [31:0]  fill_addr;
  logic         fill_pulse;
  logic         ev_pulse;
  int           cyc = 0;

  cache_dma_engine_if mif ();

  cache_dma_engine dut (
    .clk_i                  (clk),
    .rst_n_i                (rst_n),
    .addr_out_request_DMA_i (addr_req),
    .request_DMA_i          (req),
    .data_out_evict_DMA_i   (ev_data),
    .addr_out_evict_DMA_i   (addr_ev),
    .evict_DMA_i            (ev),
    .data_in_request_DMA_o  (fill_data),
    .addr_in_request_DMA_o  (fill_addr),
    .request_valid_DMA_o    (fill_pulse),
    .evict_DMA_o            (ev_pulse),
    .mem                    (mif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  typedef struct packed {
    logic        is_fill;
    logic [31:0] addr;
    logic [511:0] line;
    logic        chk_cyc;
    logic [31:0] cyc;
  } cpl_t;

  mem_txn_t exp_mem[$];
  cpl_t     exp_cpl[$];
  logic [31:0] store [logic [31:0]];

  int n_checks = 0;
  int n_fail   = 0;
  int gnt_delay = 0;
  int rv_delay  = 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input logic [31:0] base_val);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = base_val + 32'(i);
    return l;
  endfunction

  // Memory model: grants after gnt_delay stalled cycles, answers reads rv_delay cycles later.
  initial begin
    int       stall_cnt;
    bit       rv_pend;
    int       rv_wait;
    logic [31:0] rv_data;
    mem_txn_t hold;
    mem_txn_t e;
    stall_cnt = 0; rv_pend = 0; rv_wait = 0; rv_data = 32'h0;
    hold = '0;
    mif.mem_gnt_i = 1'b0; mif.mem_rvalid_i = 1'b0; mif.mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      mif.mem_rvalid_i = 1'b0;
      if (rv_pend) begin
        rv_wait--;
        if (rv_wait == 0) begin
          mif.mem_rvalid_i = 1'b1;
          mif.mem_rdata_i  = rv_data;
          rv_pend = 0;
        end
      end
      mif.mem_gnt_i = 1'b0;
      if (mif.mem_req_o === 1'b1) begin
        if (stall_cnt == 0) begin
          hold = '{mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o};
        end else begin
          check("stall addr", {480'h0, mif.mem_addr_o}, {480'h0, hold.addr});
          check("stall we", {511'h0, mif.mem_we_o}, {511'h0, hold.we});
          check("stall wdata", {480'h0, mif.mem_wdata_o}, {480'h0, hold.data});
        end
        if (stall_cnt >= gnt_delay) begin
          mif.mem_gnt_i = 1'b1;
          stall_cnt = 0;
          if (exp_mem.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected mem txn: we=%0b addr=%h, expected none", mif.mem_we_o, mif.mem_addr_o);
          end else begin
            e = exp_mem.pop_front();
            check("mem we", {511'h0, mif.mem_we_o}, {511'h0, e.we});
            check("mem addr", {480'h0, mif.mem_addr_o}, {480'h0, e.addr});
            if (e.we) check("mem wdata", {480'h0, mif.mem_wdata_o}, {480'h0, e.data});
          end
          if (mif.mem_we_o === 1'b1) begin
            store[mif.mem_addr_o] = mif.mem_wdata_o;
          end else begin
            rv_pend = 1;
            rv_wait = rv_delay;
            rv_data = store.exists(mif.mem_addr_o) ? store[mif.mem_addr_o]
                                                   : 32'hA000_0000 + ((mif.mem_addr_o >> 2) & 32'hF);
          end
        end else begin
          stall_cnt++;
        end
      end else begin
        stall_cnt = 0;
      end
    end
  end

  // Completion monitor: every pulse must match the oldest expected completion.
  initial begin
    cpl_t c;
    forever begin
      @(negedge clk);
      if (fill_pulse === 1'b1 || ev_pulse === 1'b1) begin
        if (exp_cpl.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected pulse: fill=%0b evict=%0b, expected none", fill_pulse, ev_pulse);
        end else begin
          c = exp_cpl.pop_front();
          check("pulse kind", {510'h0, fill_pulse, ev_pulse}, {510'h0, c.is_fill, ~c.is_fill});
          if (c.is_fill) begin
            check("fill addr", {480'h0, fill_addr}, {480'h0, c.addr});
            check("fill data", fill_data, c.line);
          end
          if (c.chk_cyc) check("pulse latency", {480'h0, 32'(cyc)}, {480'h0, c.cyc});
        end
      end
    end
  end

  task automatic push_rw(input bit we, input logic [31:0] base, input logic [511:0] line, input int n);
    for (int i = 0; i < n; i++) exp_mem.push_back('{we, base + 32'(4*i), we ? line[32*i +: 32] : 32'h0});
  endtask

  task automatic wait_pulse(input bit fill, input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < 800 && !seen; k++) begin
      @(negedge clk);
      if (fill ? (fill_pulse === 1'b1) : (ev_pulse === 1'b1)) seen = 1;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no pulse within 800 cycles, expected one", name);
    end
  endtask

  task automatic run_fill(input logic [31:0] a, input logic [31:0] exp_a, input logic [511:0] exp_line,
                          input int lat, input bit hold_extra);
    push_rw(1'b0, exp_a, '0, 16);
    exp_cpl.push_back('{1'b1, exp_a, exp_line, lat >= 0, 32'(cyc + lat)});
    addr_req = a; req = 1'b1;
    wait_pulse(1'b1, "fill");
    @(negedge clk);
    if (hold_extra) @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_evict(input logic [31:0] a, input logic [31:0] exp_a, input logic [511:0] line);
    push_rw(1'b1, exp_a, line, 16);
    exp_cpl.push_back('{1'b0, exp_a, '0, 1'b1, 32'(cyc + 17)});
    addr_ev = a; ev_data = line; ev = 1'b1;
    wait_pulse(1'b0, "evict");
    @(negedge clk);
    ev = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int nrv;
    rst_n = 1'b0; req = 1'b0; ev = 1'b0; addr_req = 32'h0; addr_ev = 32'h0; ev_data = '0;
    repeat (3) @(negedge clk);
    check("reset fill pulse", {511'h0, fill_pulse}, 512'h0);
    check("reset evict pulse", {511'h0, ev_pulse}, 512'h0);
    check("reset mem_req", {511'h0, mif.mem_req_o}, 512'h0);
    check("reset mem_addr", {480'h0, mif.mem_addr_o}, 512'h0);
    check("reset fill data", fill_data, 512'h0);
    check("reset fill addr", {480'h0, fill_addr}, 512'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait fill, then unaligned evict and fill
    run_fill(32'h0000_1040, 32'h0000_1040, mk_line(32'hA000_0000), 33, 1'b0);
    run_evict(32'h0000_2005, 32'h0000_2000, mk_line(32'h5500_0000));
    run_fill(32'h0000_1047, 32'h0000_1040, mk_line(32'hA000_0000), 33, 1'b0);

    // Simultaneous evict and fill of the same line: writes first, then refill returns them
    push_rw(1'b1, 32'h3000, mk_line(32'h0), 16);
    push_rw(1'b0, 32'h3000, '0, 16);
    exp_cpl.push_back('{1'b0, 32'h3000, '0, 1'b1, 32'(cyc + 17)});
    exp_cpl.push_back('{1'b1, 32'h3000, mk_line(32'h0), 1'b0, 32'h0});
    addr_ev = 32'h3000; ev_data = mk_line(32'h0); ev = 1'b1;
    addr_req = 32'h3000; req = 1'b1;
    wait_pulse(1'b0, "sim evict");
    @(negedge clk); ev = 1'b0;
    wait_pulse(1'b1, "sim fill");
    @(negedge clk); req = 1'b0;
    repeat (2) @(negedge clk);

    // Backpressure: grant after 3 stalled cycles, read data 4 cycles after grant
    gnt_delay = 3; rv_delay = 4;
    run_fill(32'h0000_2000, 32'h0000_2000, mk_line(32'h5500_0000), -1, 1'b0);
    gnt_delay = 0; rv_delay = 1;

    // Reset after 5 words: the 6th read is already on the bus, nothing more may follow
    push_rw(1'b0, 32'h4000, '0, 6);
    addr_req = 32'h4000; req = 1'b1;
    nrv = 0;
    for (int k = 0; k < 200 && nrv < 5; k++) begin
      @(posedge clk);
      if (mif.mem_rvalid_i === 1'b1) nrv++;
    end
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0;
    @(negedge clk);
    check("rst mem_req", {511'h0, mif.mem_req_o}, 512'h0);
    check("rst mem_addr", {480'h0, mif.mem_addr_o}, 512'h0);
    check("rst fill data", fill_data, 512'h0);
    check("rst fill addr", {480'h0, fill_addr}, 512'h0);
    check("rst pulses", {510'h0, fill_pulse, ev_pulse}, 512'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst pending reads", {480'h0, 32'(exp_mem.size())}, 512'h0);
    run_fill(32'h0000_4000, 32'h0000_4000, mk_line(32'hA000_0000), 33, 1'b0);

    // Request held one cycle past the pulse must not be served twice
    run_fill(32'h0000_5000, 32'h0000_5000, mk_line(32'hA000_0000), 33, 1'b1);
    repeat (40) @(negedge clk);

    check("leftover mem txns", {480'h0, 32'(exp_mem.size())}, 512'h0);
    check("leftover completions", {480'h0, 32'(exp_cpl.size())}, 512'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
